// File: rtl/execute_stage_pipe.sv
// ============================================================================
//  Module   : execute_stage_pipe
//  Brief    : Parametrised EX stage with operand forwarding, stall/flush
//             control, a DW-step shift-add multiplier with busy handshake,
//             registered Z/V/N branch flags and a valid bit through EX/MEM.
//  Options  : EXECUTE_FWD_EN - when defined, ForwardAE/ForwardBE select the
//             forwarded operands; when undefined they are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage_pipe #(
   parameter int DW = 19,
   parameter int PW = 15,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ValidE,
   input  logic          FlushE,
   input  logic          RegWriteE,
   input  logic          MemWriteE,
   input  logic          ResultSrcE,
   input  logic          JumpE,
   input  logic          ALUSrcE,
   input  logic          Cant_ByteE,
   input  logic [1:0]    BranchE,
   input  logic [2:0]    ALUControlE,
   input  logic [DW-1:0] RD1E,
   input  logic [DW-1:0] RD2E,
   input  logic [DW-1:0] ImmExtE,
   input  logic [PW-1:0] PCE,
   input  logic [RW-1:0] RDE,
   input  logic [DW-1:0] ResultW,
   input  logic [1:0]    ForwardAE,
   input  logic [1:0]    ForwardBE,
   output logic          BusyE,
   output logic          PCSrcE,
   output logic [PW-1:0] PCTargetE,
   output logic          ValidM,
   output logic          RegWriteM,
   output logic          MemWriteM,
   output logic          ResultSrcM,
   output logic          Cant_ByteM,
   output logic [RW-1:0] RDM,
   output logic [DW-1:0] WriteDataM,
   output logic [DW-1:0] ALUResultM
);

   localparam logic [2:0] c_ALU_ADD = 3'b000;
   localparam logic [2:0] c_ALU_SUB = 3'b001;
   localparam logic [2:0] c_ALU_AND = 3'b010;
   localparam logic [2:0] c_ALU_OR  = 3'b011;
   localparam logic [2:0] c_ALU_XOR = 3'b100;
   localparam logic [2:0] c_ALU_SHL = 3'b101;
   localparam logic [2:0] c_ALU_SHR = 3'b110;
   localparam logic [2:0] c_ALU_MUL = 3'b111;

   localparam int c_CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [c_CW-1:0]   r_cnt;
   logic [DW-1:0]     r_acc;
   logic [DW-1:0]     r_mcand;
   logic [DW-1:0]     r_mplier;
   logic              r_h_regwrite;
   logic              r_h_memwrite;
   logic              r_h_resultsrc;
   logic              r_h_cantbyte;
   logic [RW-1:0]     r_h_rd;
   logic [DW-1:0]     r_h_wdata;
   logic              r_flag_z;
   logic              r_flag_v;
   logic              r_flag_n;

   logic [DW-1:0]     w_src_a;
   logic [DW-1:0]     w_fwd_b;
   logic [DW-1:0]     w_src_b;
   logic [DW-1:0]     w_alu_res;
   logic              w_alu_v;
   logic [4:0]        w_shamt;
   logic              w_sh_ovr;
   logic              w_mul_start;
   logic              w_br_cond;

`ifdef EXECUTE_FWD_EN
   // Operand forwarding from writeback and from the EX/MEM result
   always_comb begin
      w_src_a = RD1E;
      w_fwd_b = RD2E;
      case (ForwardAE)
         2'b01:   w_src_a = ResultW;
         2'b10:   w_src_a = ALUResultM;
         default: w_src_a = RD1E;
      endcase
      case (ForwardBE)
         2'b01:   w_fwd_b = ResultW;
         2'b10:   w_fwd_b = ALUResultM;
         default: w_fwd_b = RD2E;
      endcase
   end
`else
   logic w_unused_fwd;
   assign w_src_a      = RD1E;
   assign w_fwd_b      = RD2E;
   assign w_unused_fwd = ^{ForwardAE, ForwardBE, ResultW};
`endif

   assign w_src_b  = ALUSrcE ? ImmExtE : w_fwd_b;
   assign w_shamt  = w_src_b[4:0];
   assign w_sh_ovr = ({27'd0, w_shamt} >= 32'(DW));

   // Single-cycle ALU with signed overflow for add/sub
   always_comb begin
      w_alu_res = '0;
      w_alu_v   = 1'b0;
      case (ALUControlE)
         c_ALU_ADD: begin
            w_alu_res = w_src_a + w_src_b;
            w_alu_v   = (w_src_a[DW-1] == w_src_b[DW-1]) && (w_alu_res[DW-1] != w_src_a[DW-1]);
         end
         c_ALU_SUB: begin
            w_alu_res = w_src_a - w_src_b;
            w_alu_v   = (w_src_a[DW-1] != w_src_b[DW-1]) && (w_alu_res[DW-1] != w_src_a[DW-1]);
         end
         c_ALU_AND: w_alu_res = w_src_a & w_src_b;
         c_ALU_OR:  w_alu_res = w_src_a | w_src_b;
         c_ALU_XOR: w_alu_res = w_src_a ^ w_src_b;
         c_ALU_SHL: w_alu_res = w_sh_ovr ? '0 : (w_src_a << w_shamt);
         c_ALU_SHR: w_alu_res = w_sh_ovr ? '0 : (w_src_a >> w_shamt);
         default:   w_alu_res = '0;
      endcase
   end

   // A multiply starting in IDLE stalls upstream in the same cycle; reset masks it
   assign w_mul_start = reset && (r_state == ST_IDLE) && ValidE &&
                        (ALUControlE == c_ALU_MUL) && !FlushE;
   assign BusyE       = w_mul_start || (r_state == ST_MUL);

   // Branch condition evaluated from the registered flags
   always_comb begin
      w_br_cond = 1'b0;
      case (BranchE)
         2'b01:   w_br_cond = ~(r_flag_n ^ r_flag_v);
         2'b10:   w_br_cond = r_flag_n ^ r_flag_v;
         2'b11:   w_br_cond = r_flag_z;
         default: w_br_cond = 1'b0;
      endcase
   end

   assign PCSrcE    = reset && ValidE && !FlushE && !BusyE && (JumpE || w_br_cond);
   assign PCTargetE = PCE + ImmExtE[PW-1:0];

   // Multiplier FSM, flag register and EX/MEM pipeline register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_acc         <= '0;
         r_mcand       <= '0;
         r_mplier      <= '0;
         r_h_regwrite  <= 1'b0;
         r_h_memwrite  <= 1'b0;
         r_h_resultsrc <= 1'b0;
         r_h_cantbyte  <= 1'b0;
         r_h_rd        <= '0;
         r_h_wdata     <= '0;
         r_flag_z      <= 1'b0;
         r_flag_v      <= 1'b0;
         r_flag_n      <= 1'b0;
         ValidM        <= 1'b0;
         RegWriteM     <= 1'b0;
         MemWriteM     <= 1'b0;
         ResultSrcM    <= 1'b0;
         Cant_ByteM    <= 1'b0;
         RDM           <= '0;
         WriteDataM    <= '0;
         ALUResultM    <= '0;
      end else begin
         // A bubble is the default; retiring paths override it below
         ValidM     <= 1'b0;
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= 1'b0;
         Cant_ByteM <= 1'b0;
         RDM        <= '0;
         WriteDataM <= '0;
         ALUResultM <= '0;
         if (FlushE) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_mul_start) begin
                     // Bit 0 of the multiplier is consumed at capture, leaving DW-1 steps
                     r_acc         <= w_src_b[0] ? w_src_a : '0;
                     r_mcand       <= w_src_a << 1;
                     r_mplier      <= w_src_b >> 1;
                     r_h_regwrite  <= RegWriteE;
                     r_h_memwrite  <= MemWriteE;
                     r_h_resultsrc <= ResultSrcE;
                     r_h_cantbyte  <= Cant_ByteE;
                     r_h_rd        <= RDE;
                     r_h_wdata     <= w_fwd_b;
                     r_cnt         <= c_CW'(DW);
                     r_state       <= ST_MUL;
                  end else if (ValidE) begin
                     ValidM     <= 1'b1;
                     RegWriteM  <= RegWriteE;
                     MemWriteM  <= MemWriteE;
                     ResultSrcM <= ResultSrcE;
                     Cant_ByteM <= Cant_ByteE;
                     RDM        <= RDE;
                     WriteDataM <= w_fwd_b;
                     ALUResultM <= w_alu_res;
                     if (BranchE == 2'b00) begin
                        r_flag_z <= (w_alu_res == '0);
                        r_flag_n <= w_alu_res[DW-1];
                        r_flag_v <= w_alu_v;
                     end
                  end
               end
               ST_MUL: begin
                  r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_cnt    <= r_cnt - c_CW'(1);
                  if (r_cnt == c_CW'(2)) begin
                     r_state <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  ValidM     <= 1'b1;
                  RegWriteM  <= r_h_regwrite;
                  MemWriteM  <= r_h_memwrite;
                  ResultSrcM <= r_h_resultsrc;
                  Cant_ByteM <= r_h_cantbyte;
                  RDM        <= r_h_rd;
                  WriteDataM <= r_h_wdata;
                  ALUResultM <= r_acc;
                  if (ValidE && (BranchE == 2'b00)) begin
                     r_flag_z <= (r_acc == '0);
                     r_flag_n <= r_acc[DW-1];
                     r_flag_v <= 1'b0;
                  end
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end
               default: begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage_pipe.sv
// ============================================================================
//  Module   : tb_execute_stage_pipe
//  Brief    : Self-checking bench for execute_stage_pipe: directed cases with
//             literal expectations plus randomized traffic compared every
//             cycle against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_stage_pipe;

   localparam int DW = 19;
   localparam int PW = 15;
   localparam int RW = 5;
   localparam longint FULL  = longint'(1) << DW;
   localparam longint HALF  = longint'(1) << (DW - 1);
   localparam longint PFULL = longint'(1) << PW;

   logic          clk = 1'b0;
   logic          reset;
   logic          ValidE, FlushE, RegWriteE, MemWriteE, ResultSrcE, JumpE, ALUSrcE, Cant_ByteE;
   logic [1:0]    BranchE;
   logic [2:0]    ALUControlE;
   logic [DW-1:0] RD1E, RD2E, ImmExtE, ResultW;
   logic [PW-1:0] PCE;
   logic [RW-1:0] RDE;
   logic [1:0]    ForwardAE, ForwardBE;
   logic          BusyE, PCSrcE;
   logic [PW-1:0] PCTargetE;
   logic          ValidM, RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM;
   logic [RW-1:0] RDM;
   logic [DW-1:0] WriteDataM, ALUResultM;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state
   longint m_alu, m_wd, h_prod, h_wd;
   bit     m_valid, m_rw, m_mw, m_rs, m_cb, m_z, m_n, m_v;
   bit     h_rw, h_mw, h_rs, h_cb;
   int     m_rd, h_rd, m_occ;
   bit     last_busy;

   execute_stage_pipe #(.DW(DW), .PW(PW), .RW(RW)) dut (
      .clk(clk), .reset(reset), .ValidE(ValidE), .FlushE(FlushE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .JumpE(JumpE), .ALUSrcE(ALUSrcE), .Cant_ByteE(Cant_ByteE),
      .BranchE(BranchE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
      .ImmExtE(ImmExtE), .PCE(PCE), .RDE(RDE), .ResultW(ResultW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .BusyE(BusyE),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ValidM(ValidM),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .Cant_ByteM(Cant_ByteM), .RDM(RDM), .WriteDataM(WriteDataM),
      .ALUResultM(ALUResultM)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint sgn(input longint x);
      return (x >= HALF) ? x - FULL : x;
   endfunction

   function automatic longint fwd(input longint rd, input logic [1:0] sel);
`ifdef EXECUTE_FWD_EN
      if (sel == 2'b01) return longint'(ResultW);
      if (sel == 2'b10) return m_alu;
`endif
      return rd;
   endfunction

   function automatic bit exp_busy();
      return (m_occ == 0 && ValidE && ALUControlE == 3'd7 && !FlushE) || (m_occ > 1);
   endfunction

   function automatic bit exp_pcsrc(input bit busy);
      bit c;
      c = JumpE || (BranchE == 2'd3 && m_z) || (BranchE == 2'd1 && m_n == m_v) ||
          (BranchE == 2'd2 && m_n != m_v);
      return c && ValidE && !FlushE && !busy;
   endfunction

   task automatic model_reset();
      m_alu = 0; m_wd = 0; m_valid = 0; m_rw = 0; m_mw = 0; m_rs = 0; m_cb = 0; m_rd = 0;
      m_z = 0; m_n = 0; m_v = 0; m_occ = 0;
   endtask

   // Applies the inputs present at the clock edge to the model
   task automatic model_edge();
      longint a, fb, b, r, s, amt;
      bit v;
      a  = fwd(longint'(RD1E), ForwardAE);
      fb = fwd(longint'(RD2E), ForwardBE);
      b  = ALUSrcE ? longint'(ImmExtE) : fb;
      m_valid = 0; m_rw = 0; m_mw = 0; m_rs = 0; m_cb = 0; m_rd = 0; m_wd = 0; m_alu = 0;
      if (FlushE) begin
         m_occ = 0;
      end else if (m_occ > 1) begin
         m_occ--;
      end else if (m_occ == 1) begin
         m_valid = 1; m_rw = h_rw; m_mw = h_mw; m_rs = h_rs; m_cb = h_cb; m_rd = h_rd;
         m_wd = h_wd; m_alu = h_prod;
         if (ValidE && BranchE == 0) begin
            m_z = (h_prod == 0); m_n = (h_prod >= HALF); m_v = 0;
         end
         m_occ = 0;
      end else if (ValidE && ALUControlE == 3'd7) begin
         h_prod = (a * b) % FULL;
         h_rw = RegWriteE; h_mw = MemWriteE; h_rs = ResultSrcE; h_cb = Cant_ByteE;
         h_rd = int'(RDE); h_wd = fb;
         m_occ = DW;
      end else if (ValidE) begin
         v = 0; r = 0;
         amt = b % 32;
         case (ALUControlE)
            3'd0: begin s = sgn(a) + sgn(b); r = (a + b) % FULL; v = (s >= HALF) || (s < -HALF); end
            3'd1: begin s = sgn(a) - sgn(b); r = (a - b + FULL) % FULL; v = (s >= HALF) || (s < -HALF); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (amt >= DW) ? 0 : (a << amt) % FULL;
            default: r = (amt >= DW) ? 0 : (a >> amt);
         endcase
         m_valid = 1; m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE; m_cb = Cant_ByteE;
         m_rd = int'(RDE); m_wd = fb; m_alu = r;
         if (BranchE == 0) begin
            m_z = (r == 0); m_n = (r >= HALF); m_v = v;
         end
      end
   endtask

   // One clock: combinational checks before the edge, registered checks after
   task automatic step();
      bit eb;
      #1;
      eb = exp_busy();
      last_busy = BusyE;
      chk("BusyE", BusyE, eb);
      chk("PCSrcE", PCSrcE, exp_pcsrc(eb));
      chk("PCTargetE", PCTargetE, (longint'(PCE) + longint'(ImmExtE) % PFULL) % PFULL);
      @(posedge clk);
      model_edge();
      #1;
      chk("ValidM", ValidM, m_valid);
      chk("RegWriteM", RegWriteM, m_rw);
      chk("MemWriteM", MemWriteM, m_mw);
      chk("ResultSrcM", ResultSrcM, m_rs);
      chk("Cant_ByteM", Cant_ByteM, m_cb);
      chk("RDM", RDM, m_rd);
      chk("WriteDataM", WriteDataM, m_wd);
      chk("ALUResultM", ALUResultM, m_alu);
   endtask

   task automatic clear_inputs();
      ValidE = 0; FlushE = 0; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; JumpE = 0;
      ALUSrcE = 0; Cant_ByteE = 0; BranchE = 0; ALUControlE = 0; RD1E = 0; RD2E = 0;
      ImmExtE = 0; ResultW = 0; PCE = 0; RDE = 0; ForwardAE = 0; ForwardBE = 0;
   endtask

   task automatic set_op(input logic [2:0] op, input longint a, input longint b,
                         input bit alusrc, input longint imm, input int rd);
      clear_inputs();
      ValidE = 1; RegWriteE = 1; ALUControlE = op; RD1E = DW'(a); RD2E = DW'(b);
      ALUSrcE = alusrc; ImmExtE = DW'(imm); RDE = RW'(rd);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ValidM"}, ValidM, 0);
      chk({tag, "_RegWriteM"}, RegWriteM, 0);
      chk({tag, "_MemWriteM"}, MemWriteM, 0);
      chk({tag, "_ResultSrcM"}, ResultSrcM, 0);
      chk({tag, "_Cant_ByteM"}, Cant_ByteM, 0);
      chk({tag, "_RDM"}, RDM, 0);
      chk({tag, "_WriteDataM"}, WriteDataM, 0);
      chk({tag, "_ALUResultM"}, ALUResultM, 0);
      chk({tag, "_BusyE"}, BusyE, 0);
      chk({tag, "_PCSrcE"}, PCSrcE, 0);
   endtask

   initial begin
      int busy_cnt;
      clear_inputs();
      model_reset();
      reset = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      reset = 1;

      // Add 5+3
      set_op(3'd0, 5, 3, 0, 0, 7);
      step();
      chk("lit_add_res", ALUResultM, 8);
      chk("lit_add_rd", RDM, 7);
      chk("lit_add_valid", ValidM, 1);
      chk("lit_add_rw", RegWriteM, 1);

      // sub 3-5 sets N, then SMEE taken and SMAE not taken
      set_op(3'd1, 3, 5, 0, 0, 1);
      step();
      chk("lit_sub_res", ALUResultM, FULL - 2);
      set_op(3'd1, 3, 5, 0, 'h10, 0);
      RegWriteE = 0; BranchE = 2'b10; PCE = 'h100;
      step();
      chk("lit_smee_pcsrc", PCSrcE, 1);
      chk("lit_smee_target", PCTargetE, 'h110);
      BranchE = 2'b01;
      #1;
      chk("lit_smae_pcsrc", PCSrcE, 0);
      step();

      // Multiply 300*200, operands disturbed mid-operation
      set_op(3'd7, 300, 200, 0, 0, 9);
      busy_cnt = 0;
      for (int i = 0; i < DW + 1; i++) begin
         if (i == 6) RD1E = 'd7;
         step();
         if (last_busy) busy_cnt++;
         if (i < DW) chk("lit_mul_bubble", ValidM, 0);
      end
      chk("lit_mul_busy_cycles", busy_cnt, DW);
      chk("lit_mul_res", ALUResultM, 60000);
      chk("lit_mul_valid", ValidM, 1);

      // Forwarding from EX/MEM and from writeback
      set_op(3'd0, 'h3F, 0, 1, 1, 2);
      step();
      set_op(3'd0, 1, 0, 1, 1, 2);
      ForwardAE = 2'b10;
      step();
`ifdef EXECUTE_FWD_EN
      chk("lit_fwd_m", ALUResultM, 'h41);
`else
      chk("lit_fwd_m", ALUResultM, 2);
`endif
      ForwardAE = 2'b01; ResultW = 9;
      step();
`ifdef EXECUTE_FWD_EN
      chk("lit_fwd_w", ALUResultM, 10);
`else
      chk("lit_fwd_w", ALUResultM, 2);
`endif

      // Flush on the fifth cycle of a multiply
      set_op(3'd7, 11, 13, 0, 0, 3);
      for (int i = 0; i < 4; i++) step();
      FlushE = 1;
      step();
      set_op(3'd0, 2, 2, 0, 0, 4);
      #1;
      chk("lit_flush_busy", BusyE, 0);
      chk("lit_flush_valid", ValidM, 0);
      step();
      chk("lit_flush_add", ALUResultM, 4);
      chk("lit_flush_addv", ValidM, 1);

      // Asynchronous reset in the middle of a multiply
      set_op(3'd7, 21, 22, 0, 0, 5);
      for (int i = 0; i < 3; i++) step();
      #2;
      reset = 0;
      #1;
      chk_all_zero("async");
      model_reset();
      @(negedge clk);
      reset = 1;
      set_op(3'd0, 5, 3, 0, 0, 6);
      step();
      chk("lit_post_reset_add", ALUResultM, 8);

      // Randomized traffic; upstream holds its instruction while EX is occupied
      for (int i = 0; i < 600; i++) begin
         if (m_occ == 0) begin
            clear_inputs();
            ValidE      = ($urandom_range(0, 7) != 0);
            ALUControlE = 3'($urandom_range(0, 7));
            if (ALUControlE == 3'd7 && $urandom_range(0, 1) == 0) ALUControlE = 3'd0;
            BranchE     = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            JumpE       = ($urandom_range(0, 7) == 0);
            RegWriteE   = 1'($urandom);
            MemWriteE   = 1'($urandom);
            ResultSrcE  = 1'($urandom);
            Cant_ByteE  = 1'($urandom);
            ALUSrcE     = 1'($urandom);
            RD1E        = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom);
            RD2E        = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom);
            ImmExtE     = DW'($urandom);
            ResultW     = DW'($urandom);
            PCE         = PW'($urandom);
            RDE         = RW'($urandom);
            ForwardAE   = 2'($urandom);
            ForwardBE   = 2'($urandom);
         end
         FlushE = ($urandom_range(0, 29) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
